// File: rtl/pipe_stall_regs.sv
// pipe_stall_regs: IF/ID and ID/EX pipeline registers with stall/flush control and PC write enable.
// Optional performance counters are enabled by defining PIPE_PERF_CNT_EN.
module pipe_stall_regs #(
    parameter int IW  = 9,
    parameter int PCW = 10,
    parameter int CW  = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [IW-1:0]  fetch_instr,
    input  logic [PCW-1:0] fetch_pc,
    input  logic           fetch_valid,
    input  logic [2:0]     id_rs,
    input  logic [2:0]     id_rd,
    input  logic           id_mem_read,
    input  logic           id_mem_write,
    input  logic           id_reg_write,
    input  logic           stall,
    input  logic           flush,
    output logic           pc_write_en,
    output logic [IW-1:0]  if_id_instr,
    output logic [PCW-1:0] if_id_pc,
    output logic           if_id_valid,
    output logic           id_ex_valid,
    output logic [PCW-1:0] id_ex_pc,
    output logic [2:0]     id_ex_rs,
    output logic [2:0]     id_ex_rd,
    output logic           id_ex_mem_read,
    output logic           id_ex_mem_write,
    output logic           id_ex_reg_write,
    output logic           stall_err,
    output logic [CW-1:0]  stall_cycles,
    output logic [CW-1:0]  flush_cycles
);
    logic eff_stall;
    logic stall_hist;

    // A stall against an empty IF/ID slot is meaningless, and flush overrides it.
    assign eff_stall   = stall & if_id_valid & ~flush;
    assign pc_write_en = reset | ~eff_stall;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            if_id_valid <= 1'b0;
            if_id_instr <= '0;
            if_id_pc    <= '0;
        end else if (!eff_stall) begin
            if_id_valid <= fetch_valid;
            if_id_instr <= fetch_instr;
            if_id_pc    <= fetch_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush || eff_stall) begin
            id_ex_valid     <= 1'b0;
            id_ex_pc        <= '0;
            id_ex_rs        <= '0;
            id_ex_rd        <= '0;
            id_ex_mem_read  <= 1'b0;
            id_ex_mem_write <= 1'b0;
            id_ex_reg_write <= 1'b0;
        end else begin
            id_ex_valid     <= if_id_valid;
            id_ex_pc        <= if_id_pc;
            id_ex_rs        <= id_rs;
            id_ex_rd        <= id_rd;
            id_ex_mem_read  <= id_mem_read & if_id_valid;
            id_ex_mem_write <= id_mem_write & if_id_valid;
            id_ex_reg_write <= id_reg_write & if_id_valid;
        end
    end

    // Back-to-back effective stalls mean the hazard unit ignored the bubble it caused.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_hist <= 1'b0;
            stall_err  <= 1'b0;
        end else begin
            stall_hist <= eff_stall;
            stall_err  <= stall_err | (eff_stall & stall_hist);
        end
    end

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            if (eff_stall && !(&stall_cycles))
                stall_cycles <= stall_cycles + CW'(1);
            if (flush && !(&flush_cycles))
                flush_cycles <= flush_cycles + CW'(1);
        end
    end
`else
    assign stall_cycles = '0;
    assign flush_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_regs.sv
// tb_pipe_stall_regs: randomized bench for pipe_stall_regs against a cycle-level reference model.
module tb_pipe_stall_regs;
    localparam int IW  = 9;
    localparam int PCW = 10;
    localparam int CW  = 4;
    localparam int MAXC = (1 << CW) - 1;
`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic [IW-1:0]  fetch_instr;
    logic [PCW-1:0] fetch_pc;
    logic           fetch_valid;
    logic [2:0]     id_rs, id_rd;
    logic           id_mem_read, id_mem_write, id_reg_write;
    logic           stall, flush;
    logic           pc_write_en;
    logic [IW-1:0]  if_id_instr;
    logic [PCW-1:0] if_id_pc;
    logic           if_id_valid;
    logic           id_ex_valid;
    logic [PCW-1:0] id_ex_pc;
    logic [2:0]     id_ex_rs, id_ex_rd;
    logic           id_ex_mem_read, id_ex_mem_write, id_ex_reg_write;
    logic           stall_err;
    logic [CW-1:0]  stall_cycles, flush_cycles;

    pipe_stall_regs #(.IW(IW), .PCW(PCW), .CW(CW)) dut (
        .clk(clk), .reset(reset),
        .fetch_instr(fetch_instr), .fetch_pc(fetch_pc), .fetch_valid(fetch_valid),
        .id_rs(id_rs), .id_rd(id_rd), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
        .stall(stall), .flush(flush), .pc_write_en(pc_write_en),
        .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid),
        .id_ex_valid(id_ex_valid), .id_ex_pc(id_ex_pc), .id_ex_rs(id_ex_rs),
        .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read),
        .id_ex_mem_write(id_ex_mem_write), .id_ex_reg_write(id_ex_reg_write),
        .stall_err(stall_err), .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference state: one record per pipeline slot plus scalar bookkeeping.
    typedef struct {
        bit v;
        int instr;
        int pc;
    } if_t;
    typedef struct {
        bit v;
        int pc, rs, rd;
        bit mr, mw, rw;
    } ex_t;

    if_t m_if;
    ex_t m_ex;
    bit  m_err, m_prev;
    int  m_sc, m_fc;

    task automatic model_step();
        bit es;
        ex_t bubble;
        bubble = '{default: 0};
        es = stall && m_if.v && !flush;
        if (reset) begin
            m_if = '{default: 0};
            m_ex = bubble;
            m_err = 0; m_prev = 0; m_sc = 0; m_fc = 0;
        end else begin
            if (flush) begin
                m_ex = bubble;
                m_if = '{default: 0};
                m_fc = (m_fc == MAXC) ? m_fc : m_fc + 1;
            end else if (es) begin
                m_ex = bubble;
                m_sc = (m_sc == MAXC) ? m_sc : m_sc + 1;
            end else begin
                m_ex = '{v: m_if.v, pc: m_if.pc, rs: int'(id_rs), rd: int'(id_rd),
                         mr: id_mem_read && m_if.v, mw: id_mem_write && m_if.v,
                         rw: id_reg_write && m_if.v};
                m_if = '{v: fetch_valid, instr: int'(fetch_instr), pc: int'(fetch_pc)};
            end
            if (es && m_prev) m_err = 1;
            m_prev = es;
        end
    endtask

    task automatic check_regs();
        check("if_id_valid", 32'(if_id_valid), 32'(m_if.v));
        check("if_id_instr", 32'(if_id_instr), m_if.instr);
        check("if_id_pc", 32'(if_id_pc), m_if.pc);
        check("id_ex_valid", 32'(id_ex_valid), 32'(m_ex.v));
        check("id_ex_pc", 32'(id_ex_pc), m_ex.pc);
        check("id_ex_rs", 32'(id_ex_rs), m_ex.rs);
        check("id_ex_rd", 32'(id_ex_rd), m_ex.rd);
        check("id_ex_mem_read", 32'(id_ex_mem_read), 32'(m_ex.mr));
        check("id_ex_mem_write", 32'(id_ex_mem_write), 32'(m_ex.mw));
        check("id_ex_reg_write", 32'(id_ex_reg_write), 32'(m_ex.rw));
        check("stall_err", 32'(stall_err), 32'(m_err));
        check("stall_cycles", 32'(stall_cycles), PERF ? m_sc : 0);
        check("flush_cycles", 32'(flush_cycles), PERF ? m_fc : 0);
    endtask

    initial begin
        int pc_next;
        bit exp_pwe;
        pc_next = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            reset        = (i < 2) || ($urandom_range(0, 299) == 0);
            fetch_valid  = ($urandom_range(0, 9) < 8);
            fetch_pc     = PCW'(pc_next);
            fetch_instr  = IW'($urandom);
            id_rs        = 3'($urandom);
            id_rd        = 3'($urandom);
            id_mem_read  = 1'($urandom);
            id_mem_write = 1'($urandom);
            id_reg_write = 1'($urandom);
            stall        = ($urandom_range(0, 9) < 4);
            flush        = ($urandom_range(0, 9) == 0);
            #1;
            exp_pwe = reset || !(stall && m_if.v && !flush);
            if (i >= 2) check("pc_write_en", 32'(pc_write_en), 32'(exp_pwe));
            else check("pc_write_en_rst", 32'(pc_write_en), 32'd1);
            if (exp_pwe) pc_next = (pc_next + 1) % (1 << PCW);
            @(posedge clk);
            model_step();
            #1;
            check_regs();
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/pipe_stall_regs.md
Name: pipe_stall_regs

Overview:
- IF/ID and ID/EX pipeline registers plus PC write control. Consumes the `stall` output of the load-use hazard unit and the EX-stage branch `flush`.
- Produces the ID/EX-side fields (`id_ex_mem_read`, `id_ex_rd`) that the hazard unit compares against.
- Sits between fetch, decode and execute in the 5-stage core. It is the state-holding end of the stall/bubble protocol.

Parameters:
- IW, 9, instruction width in bits
- PCW, 10, program counter width in bits
- CW, 16, width of the performance counters

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- fetch_instr  in  IW  instruction from instruction memory
- fetch_pc  in  PCW  PC of fetch_instr
- fetch_valid  in  1  fetch_instr is a real instruction
- id_rs  in  3  source register decoded from if_id_instr
- id_rd  in  3  destination register decoded from if_id_instr
- id_mem_read  in  1  decoded load
- id_mem_write  in  1  decoded store
- id_reg_write  in  1  decoded register write
- stall  in  1  load-use stall request from the hazard unit
- flush  in  1  branch taken/redirect resolved in EX
- pc_write_en  out  1  PC register may update this cycle
- if_id_instr  out  IW  IF/ID instruction
- if_id_pc  out  PCW  IF/ID PC
- if_id_valid  out  1  IF/ID holds a real instruction
- id_ex_valid  out  1  ID/EX holds a real instruction
- id_ex_pc  out  PCW  ID/EX PC
- id_ex_rs  out  3  ID/EX source register
- id_ex_rd  out  3  ID/EX destination; goes to hazard unit ID_EX_Rd
- id_ex_mem_read  out  1  goes to hazard unit ID_EX_MemRead
- id_ex_mem_write  out  1  ID/EX store
- id_ex_reg_write  out  1  ID/EX register write
- stall_err  out  1  sticky protocol-violation flag
- stall_cycles  out  CW  effective stall cycle count
- flush_cycles  out  CW  flush cycle count

Behaviour:
- Reset values (clocked, synchronous): all IF/ID and ID/EX fields are 0, including the valid bits; stall_err=0; both counters 0.
- pc_write_en is combinational: 1 in reset.
- Definitions:
  - eff_stall = stall & if_id_valid & ~flush. A stall against an empty IF/ID is ignored.
  - Bubble means ID/EX valid, mem_read, mem_write and reg_write are 0; rs, rd and pc are 0.
- Per-cycle action, priority reset > flush > eff_stall > advance:
  - flush: IF/ID valid<=0 (instr and pc cleared to 0); ID/EX<=bubble; pc_write_en=1 so the redirect target loads.
  - eff_stall: IF/ID holds all fields; ID/EX<=bubble; pc_write_en=0.
  - advance: IF/ID<={fetch_instr, fetch_pc, fetch_valid}. ID/EX<=decoded fields and if_id_pc, with valid=if_id_valid. Control bits are ANDed with if_id_valid, so an invalid slot enters as a bubble. pc_write_en=1.
- Latency:
  - fetch to if_id_* is 1 cycle.
  - if_id to id_ex_* is 1 cycle.
  - A stall adds exactly 1 cycle per occurrence.
- Protocol check:
  - A correct hazard unit deasserts stall the cycle after eff_stall, because ID/EX now holds a bubble with mem_read=0.
  - eff_stall in two consecutive cycles sets stall_err=1.
  - stall_err stays set until reset. Its assertion does not alter pipeline behaviour.
- Stall and flush in the same cycle: flush wins. No stall is counted and the stall-history bit is cleared.
- fetch_valid=0 during advance: IF/ID valid becomes 0. The PC still advances, since fetch owns PC sequencing.
- Counters:
  - stall_cycles increments on eff_stall; flush_cycles increments on flush.
  - Both saturate at all-ones and do not wrap.
- Reset asserted mid-stall: the next edge clears all state. The held instruction is discarded and stall_err clears.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- Defined: stall_cycles and flush_cycles are implemented as described above.
- Undefined: no counter flops exist; stall_cycles and flush_cycles are tied to 0. stall_err and the pipeline behaviour are unchanged.

Test Plan:
- Straight-line code: fetch instrs 0x001, 0x002, 0x003 at pc 0, 1, 2, no stall/flush -> if_id_instr follows fetch with 1-cycle lag; id_ex_pc=0, 1, 2 on consecutive cycles; pc_write_en=1 throughout.
- Load-use: load with rd=3 reaches ID/EX with id_ex_mem_read=1 and id_ex_rd=3. stall=1 for one cycle while IF/ID holds a consumer with rs=3 -> pc_write_en=0; if_id_* unchanged; next cycle id_ex_valid=0 and id_ex_mem_read=0; consumer enters ID/EX one cycle later; stall_cycles=1.
- Flush: flush=1 with if_id_valid=1 and id_ex_valid=1 -> next cycle both valid bits are 0, pc_write_en=1 in the flush cycle, flush_cycles=1. flush=1 and stall=1 together -> flush behaviour, stall_cycles unchanged.
- Stall while empty: stall=1 with if_id_valid=0 -> pipeline advances, pc_write_en=1, stall_cycles=0, stall_err=0.
- Protocol violation: stall=1 for two cycles with if_id_valid=1 -> stall_err=1 from the second edge, and it stays 1 after stall drops.
- Reset mid-stall: assert reset during the stall cycle -> all outputs read 0 (pc_write_en=1) after the edge; stall_cycles=0. With PIPE_PERF_CNT_EN undefined, the counters read 0 in every scenario above.
